store_narrow_unit: RTL and testbench

//  Store-path counterpart of the load sign extender: narrows a 32-bit register value to

---
 rtl/store_narrow_unit.sv | 74 +++++++
 tb/tb_store_narrow_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a register value to byte/half/word and writes it one byte per handshake.
// Truncation loss and misaligned or illegal-size requests are reported with the done pulse.
module store_narrow_unit #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_data,
  input  logic [1:0]        i_req_size,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  input  logic              i_mem_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_align,
  output logic              o_trunc
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_data;
  logic [1:0]        r_last, r_idx, w_last, w_sel;
  logic              r_trunc, r_err, w_err, w_trunc, w_accept, w_wr;
  always_comb begin
    w_accept = i_req_valid && r_state == IDLE;
    w_err    = i_req_size == 2'b11 || (i_req_size == 2'b01 && i_req_addr[0]) ||
               (i_req_size == 2'b10 && i_req_addr[1:0] != 2'b00);
    w_trunc  = i_req_size == 2'b00 ? i_req_data[31:8] != {24{i_req_data[7]}} :
               i_req_size == 2'b01 ? i_req_data[31:16] != {16{i_req_data[15]}} : 1'b0;
    w_last   = i_req_size == 2'b00 ? 2'd0 : i_req_size == 2'b01 ? 2'd1 : 2'd3;
    w_next   = r_state == IDLE  ? (i_req_valid ? (w_err ? DONE : WRITE) : IDLE) :
               r_state == WRITE ? (i_mem_ack && r_idx == r_last ? DONE : WRITE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_data  <= '0;
      r_last  <= '0;
      r_idx   <= '0;
      r_trunc <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_base  <= i_req_addr;
        r_data  <= i_req_data;
        r_last  <= w_last;
        r_idx   <= '0;
        r_trunc <= w_trunc;
        r_err   <= w_err;
      end else if (r_state == WRITE && i_mem_ack && r_idx != r_last)
        r_idx <= r_idx + 2'd1;
    end
  end
  // Big-endian walks the narrowed value from its most significant byte down.
  always_comb begin
    w_wr        = r_state == WRITE;
    w_sel       = BIG_ENDIAN ? r_last - r_idx : r_idx;
    o_req_ready = r_state == IDLE;
    o_busy      = r_state != IDLE;
    o_done      = r_state == DONE;
    o_err_align = o_done && r_err;
    o_trunc     = o_done && r_trunc;
    o_mem_wr_en = w_wr;
    o_mem_addr  = w_wr ? r_base + ADDR_W'(r_idx) : '0;
    o_mem_wdata = w_wr ? r_data[{w_sel, 3'b000} +: 8] : 8'h00;
  end
endmodule

// File: tb/tb_store_narrow_unit.sv
// tb_store_narrow_unit: drives big- and little-endian instances in lockstep and checks
// every byte write, the done pulse and its flags against an arithmetic reference model.
module tb_store_narrow_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_data = '0;
  logic [1:0]  i_req_size = '0;
  logic        i_mem_ack = 1'b0;
  logic        be_ready, be_wr, be_busy, be_done, be_err, be_trunc;
  logic        le_ready, le_wr, le_busy, le_done, le_err, le_trunc;
  logic [31:0] be_addr, le_addr;
  logic [7:0]  be_wdata, le_wdata;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  store_narrow_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .i_req_valid(i_req_valid), .o_req_ready(be_ready),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_size(i_req_size),
    .o_mem_wr_en(be_wr), .o_mem_addr(be_addr), .o_mem_wdata(be_wdata), .i_mem_ack(i_mem_ack),
    .o_busy(be_busy), .o_done(be_done), .o_err_align(be_err), .o_trunc(be_trunc));

  store_narrow_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n), .i_req_valid(i_req_valid), .o_req_ready(le_ready),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_size(i_req_size),
    .o_mem_wr_en(le_wr), .o_mem_addr(le_addr), .o_mem_wdata(le_wdata), .i_mem_ack(i_mem_ack),
    .o_busy(le_busy), .o_done(le_done), .o_err_align(le_err), .o_trunc(le_trunc));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          stall_byte;
    int          stall_n;
    bit          exp_trunc;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, " idle"}, {be_ready, le_ready, be_wr, le_wr, be_busy, le_busy, be_done, le_done,
        be_err, le_err, be_trunc, le_trunc, be_addr, le_addr, be_wdata, le_wdata},
        {2'b11, 10'b0, 80'b0});
  endtask

  // Expected bytes come from the numeric value of the low n bytes; random ack when rnd=1.
  task automatic run(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                     input int sb, input int sn, input bit use_tab, input bit tt, input bit te,
                     input bit rnd);
    int                n, en, j, stall;
    bit                m_err, m_trunc, e_err, e_trunc, ack, seen;
    longint unsigned   v;
    longint            sx;
    logic [7:0]        eb, el;
    n       = s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
    m_err   = s == 2'b11 || (s == 2'b01 && a % 2 != 0) || (s == 2'b10 && a % 4 != 0);
    v       = longint'(d) & ((64'd1 << (8 * n)) - 64'd1);
    sx      = v >= (64'd1 << (8 * n - 1)) ? longint'(v) - (longint'(1) << (8 * n)) : longint'(v);
    m_trunc = s != 2'b11 && sx != longint'($signed(d));
    e_err   = use_tab ? te : m_err;
    e_trunc = use_tab ? tt : m_trunc;
    en      = e_err ? 0 : n;
    @(negedge clk);
    chk("ready before req", {be_ready, le_ready}, 2'b11);
    i_req_valid = 1'b1;
    i_req_addr  = a;
    i_req_data  = d;
    i_req_size  = s;
    j = 0;
    stall = sn;
    seen = 1'b0;
    for (int k = 1; k <= 300 && !seen; k++) begin
      @(negedge clk);
      i_req_valid = 1'b0;
      if (j == en) begin
        chk("done pulse", {be_done, le_done, be_wr, le_wr, be_busy, le_busy}, 6'b110011);
        chk("err_align", {be_err, le_err}, {e_err, e_err});
        chk("trunc", {be_trunc, le_trunc}, {e_trunc, e_trunc});
        i_mem_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        seen = 1'b1;
      end else begin
        eb = 8'(v >> (8 * (n - 1 - j)));
        el = 8'(v >> (8 * j));
        chk("write strobe", {be_wr, le_wr, be_done, le_done, be_ready, le_ready}, 6'b110000);
        chk("write addr", {be_addr, le_addr}, {a + 32'(j), a + 32'(j)});
        chk("write data", {be_wdata, le_wdata}, {eb, el});
        ack = rnd ? $urandom_range(0, 2) != 0 : !(j == sb && stall > 0);
        if (!ack && !rnd) stall--;
        i_mem_ack   = ack;
        i_req_valid = 1'($urandom_range(0, 1));
        i_req_data  = $urandom;
        i_req_size  = 2'($urandom_range(0, 3));
      end
      @(posedge clk);
      if (!seen && ack) j++;
    end
    if (!seen) chk("done timeout", 1, 0);
    @(negedge clk);
    i_mem_ack = 1'b0;
    chk_idle("after done");
  endtask

  vec_t tab[$];
  logic [31:0] ra, rd;

  initial begin
    tab.push_back('{32'h100, 32'h0000000C, 2'b00, -1, 0, 1'b0, 1'b0});
    tab.push_back('{32'h102, 32'hFFFFFFF1, 2'b01, -1, 0, 1'b0, 1'b0});
    tab.push_back('{32'h200, 32'h12345678, 2'b10, -1, 0, 1'b0, 1'b0});
    tab.push_back('{32'h104, 32'h00000100, 2'b00, -1, 0, 1'b1, 1'b0});
    tab.push_back('{32'h106, 32'h00008000, 2'b01, -1, 0, 1'b1, 1'b0});
    tab.push_back('{32'h107, 32'hFFFFFF80, 2'b00, -1, 0, 1'b0, 1'b0});
    tab.push_back('{32'h101, 32'h00001234, 2'b01, -1, 0, 1'b0, 1'b1});
    tab.push_back('{32'h202, 32'h12345678, 2'b10, -1, 0, 1'b0, 1'b1});
    tab.push_back('{32'h300, 32'h00000001, 2'b11, -1, 0, 1'b0, 1'b1});
    tab.push_back('{32'h400, 32'hCAFEBABE, 2'b10, 1, 3, 1'b0, 1'b0});
    tab.push_back('{32'hFFFFFFFC, 32'h80000000, 2'b10, 3, 2, 1'b0, 1'b0});
    i_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    i_req_valid = 1'b0;
    rst_n = 1'b1;
    foreach (tab[i])
      run(tab[i].addr, tab[i].data, tab[i].size, tab[i].stall_byte, tab[i].stall_n,
          1'b1, tab[i].exp_trunc, tab[i].exp_err, 1'b0);
    // Reset in the middle of a word store abandons it immediately.
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_addr  = 32'h300;
    i_req_data  = 32'hAABBCCDD;
    i_req_size  = 2'b10;
    @(negedge clk);
    i_req_valid = 1'b0;
    i_mem_ack   = 1'b1;
    @(negedge clk);
    chk("mid write", {be_wr, be_addr, be_wdata, le_wdata}, {1'b1, 32'h301, 8'hBB, 8'hCC});
    rst_n     = 1'b0;
    i_mem_ack = 1'b0;
    @(negedge clk);
    chk_idle("reset mid write");
    rst_n = 1'b1;
    for (int r = 0; r < 40; r++) begin
      ra = $urandom;
      rd = $urandom;
      case ($urandom_range(0, 2))
        0: rd = {{24{rd[7]}}, rd[7:0]};
        1: rd = {{16{rd[15]}}, rd[15:0]};
        default: ;
      endcase
      run(ra, rd, 2'($urandom_range(0, 3)), -1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
